// File: rtl/regfile_pkg.sv
// regfile_pkg
//   Shared constants and helpers for the multi-port register file.
//   - DEF_DATA_W / DEF_ADDR_W : default data and address widths
//   - ZERO_ADDR               : address of the hardwired-zero entry
//   - port_lsb()              : lowest bit of port 'port' inside a packed
//                               multi-port bus whose fields are 'width' bits wide
package regfile_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int ZERO_ADDR  = 0;

    function automatic int port_lsb(input int port, input int width);
        return port * width;
    endfunction

endpackage

// File: rtl/regfile_clear_seq.sv
// regfile_clear_seq
//   Hardware clear sequencer. It walks every entry of the register file once
//   after reset and zeroes it, keeping busy high for exactly 2**ADDR_W cycles.
//   A reset arriving mid-walk restarts the walk from entry 0.
// Ports:
//   clk      in   clock
//   reset    in   synchronous, active-high reset
//   busy     out  sequencer active (array not yet fully cleared)
//   clr_we   out  clear-write enable for this cycle
//   clr_addr out  entry being cleared this cycle
module regfile_clear_seq
    import regfile_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    output logic              busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    logic [ADDR_W-1:0] cnt_reg;
    logic [ADDR_W-1:0] cnt_next;
    logic              busy_reg;
    logic              busy_next;

    always_comb begin
        cnt_next  = cnt_reg;
        busy_next = busy_reg;
        if (busy_reg) begin
            cnt_next = cnt_reg + 1'b1;
            // The edge that clears the last entry ends the sequence.
            if (cnt_reg == LAST_ADDR) begin
                busy_next = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg  <= '0;
            busy_reg <= 1'b1;
        end else begin
            cnt_reg  <= cnt_next;
            busy_reg <= busy_next;
        end
    end

    // Reset itself never touches the array, so the clear write is gated by it.
    assign busy     = busy_reg;
    assign clr_we   = busy_reg & ~reset;
    assign clr_addr = cnt_reg;

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp
//   Parametrised multi-port register file for the ID stage: two write ports
//   (port 1 wins on address collision), NUM_RD combinational read ports with
//   optional same-cycle write-to-read bypass, optional hardwired-zero entry 0
//   and a hardware clear sequencer that zeroes the array after reset.
// Ports:
//   clk     in   clock
//   reset   in   synchronous, active-high reset (starts the clear sequence)
//   we0/waddr0/wdata0  in  write port 0
//   we1/waddr1/wdata1  in  write port 1 (higher priority)
//   raddr   in   packed read addresses, port i = [i*ADDR_W +: ADDR_W]
//   rdata   out  packed read data,      port i = [i*DATA_W +: DATA_W]
//   busy    out  clear sequencer active; writes ignored, reads return 0
//   dbg_nib out  entry DBG_REG bits [3:0], straight from the array
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    parameter int DBG_REG  = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     we0,
    input  logic [ADDR_W-1:0]        waddr0,
    input  logic [DATA_W-1:0]        wdata0,
    input  logic                     we1,
    input  logic [ADDR_W-1:0]        waddr1,
    input  logic [DATA_W-1:0]        wdata1,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    output logic [NUM_RD*DATA_W-1:0] rdata,
    output logic                     busy,
    output logic [3:0]               dbg_nib
);

    localparam int                DEPTH   = 1 << ADDR_W;
    localparam bit                ZERO_EN = (ZERO_REG != 0);
    localparam bit                BYP_EN  = (BYPASS != 0);
    localparam logic [ADDR_W-1:0] ZERO_A  = ADDR_W'(ZERO_ADDR);
    localparam logic [ADDR_W-1:0] DBG_A   = ADDR_W'(DBG_REG);

    logic [DATA_W-1:0] mem [DEPTH];

    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;

    regfile_clear_seq #(
        .ADDR_W (ADDR_W)
    ) u_clear_seq (
        .clk      (clk),
        .reset    (reset),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    // Write arbitration. Port 0 is suppressed on a collision with port 1 so
    // the result does not depend on statement order in the write process.
    logic w0_en;
    logic w1_en;
    logic w0_zero;
    logic w1_zero;

    always_comb begin
        w0_zero = ZERO_EN && (waddr0 == ZERO_A);
        w1_zero = ZERO_EN && (waddr1 == ZERO_A);
        w1_en   = we1 && !busy && !w1_zero;
        w0_en   = we0 && !busy && !w0_zero && !(we1 && (waddr1 == waddr0));
    end

    // clr_we is only ever high while busy, when w0_en/w1_en are low.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end
        if (w0_en) begin
            mem[waddr0] <= wdata0;
        end
        if (w1_en) begin
            mem[waddr1] <= wdata1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
            logic [ADDR_W-1:0] ra;
            logic [DATA_W-1:0] rd;

            assign ra = raddr[port_lsb(gi, ADDR_W) +: ADDR_W];

            always_comb begin
                rd = mem[ra];
                if (busy) begin
                    rd = '0;
                end else if (ZERO_EN && (ra == ZERO_A)) begin
                    rd = '0;
                end else if (BYP_EN && we1 && (waddr1 == ra)) begin
                    rd = wdata1;
                end else if (BYP_EN && we0 && (waddr0 == ra)) begin
                    rd = wdata0;
                end
            end

            assign rdata[port_lsb(gi, DATA_W) +: DATA_W] = rd;
        end
    endgenerate

    assign dbg_nib = mem[DBG_A][3:0];

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-port register file and the next generation of the ID-stage register file.
- Generalised in data width, depth and read-port count.
- Adds a second write port (for a future dual-issue / load writeback), same-cycle write-to-read bypass and a hardware clear sequencer.
- Sits in ID. Read ports feed operand muxes; write ports are driven from the WB stage.

Parameters:
DATA_W, 32, data width in bits
ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
NUM_RD, 2, number of combinational read ports (1..4)
ZERO_REG, 1, 1 = entry 0 hardwired to zero (writes dropped, reads return 0)
BYPASS, 1, 1 = read returns same-cycle write data on address match
DBG_REG, 1, entry whose low 4 bits drive dbg_nib

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
we0  in  1  write enable, port 0
waddr0  in  ADDR_W  write address, port 0
wdata0  in  DATA_W  write data, port 0
we1  in  1  write enable, port 1 (higher priority)
waddr1  in  ADDR_W  write address, port 1
wdata1  in  DATA_W  write data, port 1
raddr  in  NUM_RD*ADDR_W  packed read addresses; port i = bits [i*ADDR_W +: ADDR_W]
rdata  out  NUM_RD*DATA_W  packed read data; port i = bits [i*DATA_W +: DATA_W]
busy  out  1  clear sequencer active; writes ignored, reads return 0
dbg_nib  out  4  entry DBG_REG bits [3:0]

Behaviour:
- Clock and reset: single clock clk. Reset is synchronous, active-high and sampled on the rising edge of clk.
- While reset=1 at an edge:
  - clear counter <= 0, busy <= 1.
  - Array contents are not touched by reset itself.
- Clear sequence:
  - Each edge with reset=0 and busy=1 writes 0 to entry[counter] and increments counter.
  - The edge that writes entry DEPTH-1 sets busy <= 0.
  - busy is high for exactly DEPTH cycles after reset deasserts.
- Reset mid-clear: the sequencer restarts from entry 0 and busy stays 1.
- Writes (busy=0):
  - On an edge, entry[waddrN] <= wdataN if weN=1, for N = 0, 1.
  - If we0 and we1 both target the same address, port 1 wins and port 0 is dropped.
  - Different addresses: both writes commit in the same cycle.
  - ZERO_REG=1: any write to address 0 is dropped.
  - We0/we1 asserted while busy=1: ignored, no side effect after busy drops.
- Reads are combinational, zero latency. Priority per port i, highest first:
  1. busy=1 -> 0.
  2. ZERO_REG=1 and raddr_i=0 -> 0.
  3. BYPASS=1, we1=1, waddr1=raddr_i -> wdata1.
  4. BYPASS=1, we0=1, waddr0=raddr_i -> wdata0.
  5. Otherwise -> entry[raddr_i].
- BYPASS=0: reads return the pre-edge array value; the new value is visible the cycle after the write.
- All read ports are independent. Identical addresses on several ports return identical data.
- dbg_nib = entry[DBG_REG][3:0] straight from the array, no bypass. Reads 0 from the end of the clear sequence onward. Undefined (X) before the first completed clear.
- Reset values:
  - busy = 1.
  - rdata = 0 on all ports.
  - dbg_nib reads X until entry DBG_REG is cleared, and 0 after busy falls.
- Widths: addresses unsigned and never out of range, since DEPTH = 2**ADDR_W. No arithmetic on data.

Decomposition:
- Shared package regfile_pkg: default DATA_W/ADDR_W constants, ZERO_ADDR = 0, packed-port slice helper function.
- One natural sub-module, regfile_clear_seq: owns the counter, busy and the clear-write address/enable.
- Write arbitration, bypass and read muxing stay in regfile_mp via a generate loop over NUM_RD.

Test Plan:
- Reset 3 cycles then release -> busy=1 for exactly 32 cycles. All rdata=0 throughout. After busy falls, every raddr reads 0.
- After clear: we0=1, waddr0=5, wdata0=0xDEADBEEF; same cycle raddr0=5.
  - BYPASS=1: rdata0=0xDEADBEEF immediately.
  - BYPASS=0: rdata0=0 that cycle, 0xDEADBEEF next cycle.
- we0 and we1 both target address 7 (wdata0=0x11, wdata1=0x22) -> entry 7 = 0x22. Simultaneous writes to addresses 3 and 4 -> both commit.
- Write 0xFFFFFFFF to address 0 with ZERO_REG=1 -> rdata for raddr=0 stays 0, including the bypass cycle. Write 0xA to DBG_REG -> dbg_nib=0xA next cycle.
- Write while busy=1 (address 9, 0x55) -> entry 9 reads 0 after busy falls.
- Assert reset at clear cycle 10 -> busy stays 1 and the clear restarts, ending 32 cycles after release.
